// File: rtl/divide.sv
// Signed fixed-point divider: restoring shift-subtract on magnitudes, one bit per cycle,
// with saturation and a defined divide-by-zero result. Valid/ready handshake on both sides.
module divide #(
    parameter int W = 8,
    parameter int Q = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_stb,
    input  logic [2*W-1:0]   s_dat,
    output logic             s_rdy,
    input  logic             m_rdy,
    output logic             m_stb,
    output logic [2*W-1:0]   m_dat
);

    localparam int N  = W + Q;
    localparam int CW = $clog2(N + 1);

    localparam logic [N-1:0]        QPOS = N'((64'd1 << (W - 1)) - 64'd1);
    localparam logic [N-1:0]        QNEG = N'(64'd1 << (W - 1));
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;

    logic            neg_a, neg_b, zero_b;
    logic [N-1:0]    num;
    logic [W-1:0]    rem;
    logic [W-1:0]    den;

    logic signed [W-1:0] opa, opb;
    logic [W:0]          rem_sh;
    logic                ge;
    logic [W-1:0]        rem_nxt;
    logic [N-1:0]        num_nxt;

    // Unsigned W-bit magnitude; -2^(W-1) maps to 2^(W-1) without overflow.
    function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
        logic signed [W-1:0] n;
        n   = -v;
        mag = v[W-1] ? W'(n) : W'(v);
    endfunction

    // Apply signs, saturation and the divide-by-zero rule to the magnitude result.
    function automatic logic [2*W-1:0] pack(
        input logic          na,
        input logic          nb,
        input logic          zb,
        input logic [N-1:0]  qm,
        input logic [W-1:0]  rm
    );
        logic signed [W-1:0] q;
        logic signed [W-1:0] r;
        q = W'(qm);
        r = na ? -$signed(rm) : $signed(rm);
        if (zb) begin
            q = na ? SMIN : SMAX;
            r = '0;
        end else if (na ^ nb) begin
            if (qm > QNEG) begin
                q = SMIN;
                r = '0;
            end else begin
                q = -$signed(W'(qm));
            end
        end else if (qm > QPOS) begin
            q = SMAX;
            r = '0;
        end
        pack = {r, q};
    endfunction

    assign opa = s_dat[0+:W];
    assign opb = s_dat[W+:W];

    assign s_rdy = (state == IDLE);
    assign m_stb = (state == DONE);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh  = {rem, num[N-1]};
        ge      = (rem_sh >= {1'b0, den});
        rem_nxt = ge ? W'(rem_sh - {1'b0, den}) : rem_sh[W-1:0];
        num_nxt = {num[N-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_stb) state_nxt = CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    if (m_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            m_dat <= '0;
        end else begin
            case (state)
                IDLE: if (s_stb) cnt <= CW'(N);
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        m_dat <= pack(neg_a, neg_b, zero_b, num_nxt, rem_nxt);
                end
                default: ;
            endcase
        end
    end

    // Operand datapath: loaded at accept, advanced once per CALC cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && s_stb) begin
            neg_a  <= opa[W-1];
            neg_b  <= opb[W-1];
            zero_b <= (opb == '0);
            num    <= N'(mag(opa)) << Q;
            den    <= mag(opb);
            rem    <= '0;
        end else if (state == CALC) begin
            num    <= num_nxt;
            rem    <= rem_nxt;
        end
    end

endmodule

// File: tb/tb_divide.sv
// Bench for divide: two instances (Q=0 and Q=4), directed vectors pushed to per-instance
// queues at accept, monitors pop and compare result and latency when m_stb rises.
module tb_divide;

    typedef struct {
        logic [15:0] dat;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        s_stb0, s_stb4;
    logic [15:0] s_dat0, s_dat4;
    logic        s_rdy0, s_rdy4;
    logic        m_rdy0, m_rdy4;
    logic        m_stb0, m_stb4;
    logic [15:0] m_dat0, m_dat4;
    logic        prev0, prev4;

    int   cyc;
    int   checks;
    int   failures;
    exp_t q0[$];
    exp_t q4[$];

    divide #(.W(8), .Q(0)) dut0 (
        .clk(clk), .rst(rst), .s_stb(s_stb0), .s_dat(s_dat0), .s_rdy(s_rdy0),
        .m_rdy(m_rdy0), .m_stb(m_stb0), .m_dat(m_dat0)
    );

    divide #(.W(8), .Q(4)) dut4 (
        .clk(clk), .rst(rst), .s_stb(s_stb4), .s_dat(s_dat4), .s_rdy(s_rdy4),
        .m_rdy(m_rdy4), .m_stb(m_stb4), .m_dat(m_dat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (m_stb0 && !prev0) begin
            if (q0.size() == 0) begin
                check("q0_spurious_m_stb", 32'(m_dat0), 32'hFFFF_FFFF);
            end else begin
                check("q0_dat", 32'(m_dat0), 32'(q0[0].dat));
                check("q0_latency", 32'(cyc - q0[0].acc), 32'(q0[0].lat));
                void'(q0.pop_front());
            end
        end
        prev0 <= m_stb0;
    end

    always @(negedge clk) begin
        if (m_stb4 && !prev4) begin
            if (q4.size() == 0) begin
                check("q4_spurious_m_stb", 32'(m_dat4), 32'hFFFF_FFFF);
            end else begin
                check("q4_dat", 32'(m_dat4), 32'(q4[0].dat));
                check("q4_latency", 32'(cyc - q4[0].acc), 32'(q4[0].lat));
                void'(q4.pop_front());
            end
        end
        prev4 <= m_stb4;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input bit push);
        exp_t e;
        int   n;
        n = 0;
        while (((d == 0) ? !s_rdy0 : !s_rdy4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("issue_wait_s_rdy", 32'(n), 32'd0);
        if (d == 0) begin
            s_stb0 = 1'b1;
            s_dat0 = {b, a};
        end else begin
            s_stb4 = 1'b1;
            s_dat4 = {b, a};
        end
        @(posedge clk);
        #1;
        s_stb0 = 1'b0;
        s_stb4 = 1'b0;
        s_dat0 = 16'($urandom);
        s_dat4 = 16'($urandom);
        e.dat = {er, eq};
        e.acc = cyc;
        e.lat = (d == 0) ? 8 : 12;
        if (push) begin
            if (d == 0) q0.push_back(e);
            else        q4.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (q0.size() != 0 || q4.size() != 0); n++)
            @(negedge clk);
        check("drain_pending", 32'(q0.size() + q4.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        s_stb0   = 1'b0;
        s_stb4   = 1'b0;
        s_dat0   = '0;
        s_dat4   = '0;
        m_rdy0   = 1'b1;
        m_rdy4   = 1'b1;
        prev0    = 1'b0;
        prev4    = 1'b0;

        #3 rst = 1'b0;
        #1;
        check("rst_s_rdy0", 32'(s_rdy0), 32'd1);
        check("rst_m_stb0", 32'(m_stb0), 32'd0);
        check("rst_m_dat0", 32'(m_dat0), 32'd0);
        check("rst_s_rdy4", 32'(s_rdy4), 32'd1);
        check("rst_m_stb4", 32'(m_stb4), 32'd0);
        check("rst_m_dat4", 32'(m_dat4), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Q=0 directed vectors: dividend, divisor, quotient, remainder
        issue(0, 8'd100, 8'd7,  8'h0E, 8'h02, 1);
        issue(0, 8'h9C,  8'd7,  8'hF2, 8'hFE, 1);
        issue(0, 8'h80,  8'hFF, 8'h7F, 8'h00, 1);
        issue(0, 8'd5,   8'd0,  8'h7F, 8'h00, 1);
        issue(0, 8'hFB,  8'd0,  8'h80, 8'h00, 1);
        issue(0, 8'd0,   8'd5,  8'h00, 8'h00, 1);
        issue(0, 8'd0,   8'hFB, 8'h00, 8'h00, 1);
        issue(0, 8'd7,   8'h80, 8'h00, 8'h07, 1);
        issue(0, 8'h80,  8'd7,  8'hEE, 8'hFE, 1);
        issue(0, 8'h80,  8'd1,  8'h80, 8'h00, 1);
        issue(0, 8'd127, 8'hFF, 8'h81, 8'h00, 1);
        issue(0, 8'h80,  8'h80, 8'h01, 8'h00, 1);
        drain();

        // Q=4 directed vectors
        issue(4, 8'h18, 8'h20, 8'h0C, 8'h00, 1);
        issue(4, 8'h10, 8'h08, 8'h20, 8'h00, 1);
        issue(4, 8'h40, 8'h01, 8'h7F, 8'h00, 1);
        issue(4, 8'hED, 8'h05, 8'hC4, 8'hFC, 1);
        issue(4, 8'hC0, 8'h01, 8'h80, 8'h00, 1);
        drain();

        // Backpressure in DONE
        m_rdy0 = 1'b0;
        issue(0, 8'd100, 8'd7, 8'h0E, 8'h02, 1);
        for (int n = 0; n < 30 && !m_stb0; n++) @(negedge clk);
        check("bp_m_stb_rise", 32'(m_stb0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_m_stb_hold", 32'(m_stb0), 32'd1);
            check("bp_m_dat_hold", 32'(m_dat0), 32'h020E);
            check("bp_s_rdy_low", 32'(s_rdy0), 32'd0);
            @(negedge clk);
        end
        m_rdy0 = 1'b1;
        @(negedge clk);
        check("bp_s_rdy_after", 32'(s_rdy0), 32'd1);
        check("bp_m_stb_after", 32'(m_stb0), 32'd0);
        drain();

        // Reset during CALC aborts; first edge after release accepts
        issue(0, 8'd50, 8'd3, 8'h00, 8'h00, 0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_m_stb", 32'(m_stb0), 32'd0);
        check("abort_s_rdy", 32'(s_rdy0), 32'd1);
        check("abort_m_dat", 32'(m_dat0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("release_s_rdy", 32'(s_rdy0), 32'd1);
        issue(0, 8'd100, 8'd7, 8'h0E, 8'h02, 1);
        drain();
        repeat (12) @(negedge clk);
        check("post_idle_m_stb", 32'(m_stb0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divide.md
DIVIDE -- requirements
Module: divide

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits (W >= 2).
REQ-002 The block SHALL have parameter Q, default 0, giving the fractional bits of the signed fixed-point operands (0 <= Q <= W-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port s_stb, input, 1 bit: the operand pair is valid.
REQ-006 The block SHALL have port s_dat, input, 2*W bits: [0+:W] is the signed dividend and [W+:W] is the signed divisor.
REQ-007 The block SHALL have port s_rdy, output, 1 bit: the block accepts an operand pair.
REQ-008 The block SHALL have port m_rdy, input, 1 bit: the downstream accepts the result.
REQ-009 The block SHALL have port m_stb, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port m_dat, output, 2*W bits: [0+:W] is the signed quotient and [W+:W] is the signed remainder.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-012 s_rdy SHALL be 1 exactly in IDLE, and m_stb SHALL be 1 exactly in DONE.
REQ-013 A transfer SHALL occur on an edge where the strobe and ready of that port are both 1; s_stb without s_rdy SHALL have no effect.
REQ-014 IDLE: on accept, the block SHALL latch the operand signs, |dividend|<<Q (W+Q bits), |divisor| and a zero flag, load the step counter with W+Q, and go to CALC.
REQ-015 CALC: each edge SHALL perform one restoring shift-subtract step on magnitudes and decrement the counter; the edge that completes step W+Q SHALL go to DONE with m_dat valid.
REQ-016 Latency: m_stb SHALL rise at the (W+Q)th rising edge after the accepting edge; this is fixed for all operand values, including divide-by-zero.
REQ-017 DONE: m_dat SHALL be held stable until m_stb & m_rdy; on that edge the block SHALL go to IDLE, so s_rdy = 1 on the next cycle.
REQ-018 Throughput SHALL be at most one operation per W+Q+2 cycles; no new operand is accepted while in CALC or DONE.
REQ-019 The quotient SHALL be trunc((dividend*2^Q)/divisor), rounded toward zero.
REQ-020 The remainder SHALL be (dividend*2^Q) - quotient*divisor, carry the sign of the dividend, and have magnitude < |divisor|.
REQ-021 A positive true quotient > 2^(W-1)-1 SHALL saturate to 2^(W-1)-1, with remainder 0.
REQ-022 A negative true quotient < -2^(W-1) SHALL saturate to -2^(W-1), with remainder 0.
REQ-023 For divisor = 0, the quotient SHALL be 2^(W-1)-1 if dividend >= 0, else -2^(W-1), with remainder 0.
REQ-024 A dividend of 0 with a nonzero divisor SHALL give quotient 0 and remainder 0.
REQ-025 The most-negative operand (-2^(W-1)) SHALL be handled correctly as dividend and as divisor, with no magnitude overflow.
REQ-026 The result SHALL depend only on the operands latched at accept; s_dat changes after accept SHALL have no effect.

Reset
REQ-027 While rst = 0, state SHALL be IDLE, the counter 0, s_rdy = 1, m_stb = 0 and m_dat = 0, asynchronously and regardless of clk.
REQ-028 Reset asserted in CALC or DONE SHALL abort the operation, with no m_stb pulse after release.
REQ-029 The first edge after rst returns to 1 SHALL be able to accept an operand pair.

Verification
REQ-030 The bench SHALL cover these directed scenarios (W=8 unless stated):
- Q=0, dividend 100, divisor 7 -> m_stb 8 edges after accept; m_dat[7:0]=0x0E, m_dat[15:8]=0x02.
- Q=0, -100/7 -> quotient 0xF2, remainder 0xFE; -128/-1 -> quotient 0x7F, remainder 0x00 (saturation).
- Q=0, 5/0 -> quotient 0x7F, remainder 0x00; -5/0 -> quotient 0x80, remainder 0x00; both at the fixed 8-edge latency.
- Q=4, dividend 0x18 (1.5), divisor 0x20 (2.0) -> quotient 0x0C (0.75), remainder 0x00, m_stb 12 edges after accept.
- Backpressure: hold m_rdy=0 for 5 cycles in DONE -> m_stb=1, m_dat stable, s_rdy=0 throughout; m_rdy=1 -> s_rdy=1 next cycle.
- Reset mid-CALC (rst=0 at step 4) -> m_stb=0, s_rdy=1 immediately; the next op 100/7 gives 0x0E/0x02.
